pingpong_drain_ctrl: RTL

- Sits directly downstream of the two AXI-fed blocking buffers in the double-buffer datapath.
- Drains the full buffers in strict alternation (0, 1, 0, 1, ...) and drives each buffer's stall input.
- Returns each buffer's 1-cycle-latency read data as one valid/ready stream with a last flag per buffer drain.
- Output feeds the systolic-array feeder.

---
 rtl/pingpong_drain_pkg.sv | 18 +
 rtl/drain_out_fifo.sv | 61 ++++++
 rtl/pingpong_drain_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/pingpong_drain_pkg.sv
// Shared types for the ping-pong buffer drain controller.
package pingpong_drain_pkg;

  localparam int NUM_BUF_lp  = 2;
  localparam int DRAIN_DW_lp = 64;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FLUSH
  } drain_state_t;

  typedef struct packed {
    logic [DRAIN_DW_lp-1:0] data;
    logic                   last;
  } drain_entry_t;

endpackage

// File: rtl/drain_out_fifo.sv
// Small synchronous FIFO holding drained elements and their last tags.
module drain_out_fifo
  import pingpong_drain_pkg::*;
#(
  parameter type entry_t = drain_entry_t,
  parameter int  DEPTH_g = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           push_i,
  input  entry_t                         push_entry_i,
  input  logic                           pop_i,
  output entry_t                         head_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [$clog2(DEPTH_g+1)-1:0]   count_o
);

  localparam int PTR_W_lp   = (DEPTH_g > 1) ? $clog2(DEPTH_g) : 1;
  localparam int COUNT_W_lp = $clog2(DEPTH_g + 1);

  entry_t                mem_q [DEPTH_g];
  logic [PTR_W_lp-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W_lp-1:0]   rd_ptr_q, rd_ptr_d;
  logic [COUNT_W_lp-1:0] count_q, count_d;
  logic                  do_push, do_pop;

  assign full_o  = (count_q == COUNT_W_lp'(DEPTH_g));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // NOTE: every variable written in always_comb gets a default first, so no path leaves a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W_lp'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W_lp'(do_pop);
    count_d  = count_q + COUNT_W_lp'(do_push) - COUNT_W_lp'(do_pop);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; pointers and count alone decide which entries are valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry_i;
  end

endmodule

// File: rtl/pingpong_drain_ctrl.sv
// Drains two blocking buffers in strict alternation into one valid/ready
// stream, issuing reads only when the output FIFO has guaranteed room.
module pingpong_drain_ctrl
  import pingpong_drain_pkg::*;
#(
  parameter int AXI_DW_g     = 64,
  parameter int ELEMS_g      = 16,
  parameter int FIFO_DEPTH_g = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_BUF_lp-1:0]          buf_pushing_i,
  input  logic [NUM_BUF_lp*AXI_DW_g-1:0] buf_data_i,
  output logic [NUM_BUF_lp-1:0]          buf_stall_o,
  output logic                           m_valid_o,
  input  logic                           m_ready_i,
  output logic [AXI_DW_g-1:0]            m_data_o,
  output logic                           m_last_o,
  output logic                           sel_o,
  output logic                           err_o
);

  localparam int ISSUE_W_lp = $clog2(ELEMS_g + 1);
  localparam int COUNT_W_lp = $clog2(FIFO_DEPTH_g + 1);

  typedef struct packed {
    logic [AXI_DW_g-1:0] data;
    logic                last;
  } entry_t;

  drain_state_t          state_q, state_d;
  logic                  sel_q, sel_d;
  logic                  next_sel_q, next_sel_d;
  logic [ISSUE_W_lp-1:0] issue_cnt_q, issue_cnt_d;
  logic                  inflight_q, inflight_d;
  logic                  last_tag_q, last_tag_d;
  logic                  err_q, err_d;

  logic                  issue;
  logic                  credit_ok;
  logic                  overflow;
  entry_t                push_entry, head;
  logic                  fifo_full, fifo_empty, fifo_pop;
  logic [COUNT_W_lp-1:0] fifo_count;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      sel_q       <= 1'b0;
      next_sel_q  <= 1'b0;
      issue_cnt_q <= '0;
      inflight_q  <= 1'b0;
      last_tag_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      next_sel_q  <= next_sel_d;
      issue_cnt_q <= issue_cnt_d;
      inflight_q  <= inflight_d;
      last_tag_q  <= last_tag_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    next_sel_d  = next_sel_q;
    issue_cnt_d = issue_cnt_q;
    inflight_d  = issue;
    last_tag_d  = issue && (issue_cnt_q == ISSUE_W_lp'(ELEMS_g - 1));
    err_d       = err_q || overflow;
    unique case (state_q)
      IDLE: begin
        if (buf_pushing_i[next_sel_q]) begin
          sel_d   = next_sel_q;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (issue) begin
          issue_cnt_d = issue_cnt_q + ISSUE_W_lp'(1);
          if (issue_cnt_q == ISSUE_W_lp'(ELEMS_g - 1)) state_d = FLUSH;
        end else if (!buf_pushing_i[sel_q]) begin
          // Buffer withdrew mid-drain: abandon it without ever tagging a last.
          err_d   = 1'b1;
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (!inflight_q) begin
          next_sel_d  = ~sel_q;
          issue_cnt_d = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Credit counts the read still in flight so a captured element always has a slot.
  always_comb begin
    credit_ok   = (int'(fifo_count) + int'(inflight_q)) < FIFO_DEPTH_g;
    issue       = (state_q == DRAIN) && buf_pushing_i[sel_q] && credit_ok
                  && (issue_cnt_q < ISSUE_W_lp'(ELEMS_g));
    buf_stall_o = {~(issue && sel_q), ~(issue && !sel_q)};
  end

  assign fifo_pop        = m_valid_o && m_ready_i;
  assign overflow        = inflight_q && fifo_full && !m_ready_i;
  assign push_entry.data = sel_q ? buf_data_i[2*AXI_DW_g-1:AXI_DW_g] : buf_data_i[AXI_DW_g-1:0];
  assign push_entry.last = last_tag_q;

  drain_out_fifo #(
    .entry_t (entry_t),
    .DEPTH_g (FIFO_DEPTH_g)
  ) u_out_fifo (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .push_i       (inflight_q),
    .push_entry_i (push_entry),
    .pop_i        (fifo_pop),
    .head_o       (head),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .count_o      (fifo_count)
  );

  assign m_valid_o = !fifo_empty;
  assign m_data_o  = head.data;
  assign m_last_o  = !fifo_empty && head.last;
  assign sel_o     = sel_q;
  assign err_o     = err_q;

endmodule
